fifo_ctrl: RTL

//  Sequencing controller for the dual-port block-RAM FIFO buffer in buff_break_join.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_out_skid.sv | 66 ++++++
 rtl/fifo_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the block-RAM FIFO controller and its output skid buffer.
package fifo_pkg;

    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } skid_state_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry output skid buffer: absorbs RAM read data arriving one cycle after issue.
// Entry 0 is always the head; the state encodes the occupancy directly.
module fifo_out_skid
    import fifo_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push_i,
    input  logic [WORD_SIZE-1:0] data_i,
    input  logic                 pop_i,
    output logic [WORD_SIZE-1:0] data_o,
    output logic                 valid_o,
    output logic [1:0]           cnt_o
);

    skid_state_t          state_q, state_d;
    logic [WORD_SIZE-1:0] ent0_q, ent0_d, ent1_q, ent1_d;

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_EMPTY;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        ent0_q <= ent0_d;
        ent1_q <= ent1_d;
    end

    always_comb begin
        state_d = state_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        case (state_q)
            S_EMPTY: begin
                if (push_i) begin
                    state_d = S_ONE;
                    ent0_d  = data_i;
                end
            end
            S_ONE: begin
                case ({push_i, pop_i})
                    2'b10: begin state_d = S_TWO; ent1_d = data_i; end
                    2'b01: state_d = S_EMPTY;
                    2'b11: ent0_d = data_i;
                    default: ;
                endcase
            end
            S_TWO: begin
                // The read issuer never lets a capture land on a full skid without a pop.
                case ({push_i, pop_i})
                    2'b01: begin state_d = S_ONE; ent0_d = ent1_q; end
                    2'b11: begin ent0_d = ent1_q; ent1_d = data_i; end
                    default: ;
                endcase
            end
            default: state_d = S_EMPTY;
        endcase
    end

    assign data_o  = ent0_q;
    assign valid_o = (state_q != S_EMPTY);
    assign cnt_o   = state_q;

endmodule

// File: rtl/fifo_ctrl.sv
// First-word-fall-through FIFO controller around an external 1-cycle-latency dual-port RAM.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter  int MEM_SIZE  = 64,
    parameter  int WORD_SIZE = 32,
    localparam int AW        = addr_w(MEM_SIZE),
    localparam int LW        = $clog2(MEM_SIZE + 3)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LW-1:0]        level,
    output logic                 ram_w_enable,
    output logic [AW-1:0]        ram_w_addr,
    output logic [WORD_SIZE-1:0] ram_data_in,
    output logic [AW-1:0]        ram_r_addr,
    input  logic [WORD_SIZE-1:0] ram_data_out
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                 ovf_err,
    output logic                 unf_err
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(MEM_SIZE);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   mem_cnt_q, mem_cnt_d;
    logic          pend_q, pend_d;
    logic [LW-1:0] level_q, level_d;

    logic       push, pop, rd_go;
    logic [1:0] skid_cnt;
    logic [2:0] skid_occ;

    assign in_ready = (mem_cnt_q != FULL_CNT);
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // Words the skid will hold after this edge, before any new issue lands.
    assign skid_occ = {1'b0, skid_cnt} + {2'b0, pend_q} - {2'b0, pop};
    assign rd_go    = (mem_cnt_q != '0) && (skid_occ < 3'd2);

    always_comb begin
        wr_ptr_d  = push  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = rd_go ? rd_ptr_q + AW'(1) : rd_ptr_q;
        mem_cnt_d = mem_cnt_q + (AW+1)'(push) - (AW+1)'(rd_go);
        pend_d    = rd_go;
        // Reads and captures only move words between stages; the total changes on push/pop.
        level_d   = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            pend_q    <= 1'b0;
            level_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            pend_q    <= pend_d;
            level_q   <= level_d;
        end
    end

    fifo_out_skid #(
        .WORD_SIZE (WORD_SIZE)
    ) u_skid (
        .clock   (clock),
        .reset   (reset),
        .push_i  (pend_q),
        .data_i  (ram_data_out),
        .pop_i   (pop),
        .data_o  (out_data),
        .valid_o (out_valid),
        .cnt_o   (skid_cnt)
    );

    assign ram_w_enable = push;
    assign ram_w_addr   = wr_ptr_q;
    assign ram_data_in  = in_data;
    assign ram_r_addr   = rd_ptr_q;
    assign level        = level_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, unf_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (in_valid && !in_ready)  ovf_q <= 1'b1;
            if (out_ready && !out_valid) unf_q <= 1'b1;
        end
    end

    assign ovf_err = ovf_q;
    assign unf_err = unf_q;
`endif

endmodule
